// File: rtl/bin16_to_bcd_seq.sv
// Sequential double-dabble converter: signed/unsigned binary to packed BCD,
// one bit per clock, with a start/busy/done handshake.
module bin16_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     count_q, count_d;
  logic              neg_q, neg_d;
  logic              sign_q, sign_d;
  logic [BW-1:0]     bcd_q, bcd_d;

  logic [BW-1:0]     adjusted;
  logic [BW-1:0]     shifted;
  logic [3:0]        digit;
  logic              negIn;

  // Add-3 correction on every digit that would overflow past 9 when doubled.
  always_comb begin
    adjusted = '0;
    digit    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = scratch_q[4*i +: 4];
      adjusted[4*i +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
    end
    shifted = {adjusted[BW-2:0], mag_q[WIDTH-1]};
  end

  assign negIn = SIGNED & value[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    neg_d     = neg_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          neg_d     = negIn;
          mag_d     = negIn ? (~value + ONE) : value;
          scratch_d = '0;
          count_d   = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        scratch_d = shifted;
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        count_d   = count_q + 1'b1;
        // Results are published only on the final shift so outputs never show partial values.
        if (count_q == LAST) begin
          bcd_d   = shifted;
          sign_d  = neg_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sign = sign_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// Self-checking bench for bin16_to_bcd_seq: signed and unsigned builds side by side,
// table-driven conversions plus handshake and reset corner sequences.
module tb_bin16_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] value;

  logic        busyS, doneS, signS;
  logic [19:0] bcdS;
  logic        busyU, doneU, signU;
  logic [19:0] bcdU;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] vin;
    logic        expSign;
    logic [19:0] expBcd;
    logic [19:0] expBcdU;
  } vec_t;

  vec_t vecs[8];

  bin16_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) dutS (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (value),
    .busy  (busyS),
    .done  (doneS),
    .sign  (signS),
    .bcd   (bcdS)
  );

  bin16_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) dutU (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (value),
    .busy  (busyU),
    .done  (doneU),
    .sign  (signU),
    .bcd   (bcdU)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison; every failure prints a single FAIL line
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive start for exactly one accepted edge (E0)
  task automatic applyStimulus(input logic [15:0] v);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Full conversion with cycle-exact handshake timing on both builds
  task automatic runConversion(input logic [15:0] v, input logic eSign,
                               input logic [19:0] eBcd, input logic [19:0] eBcdU);
    applyStimulus(v);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      checkOutput("done_timing", {31'b0, doneS}, {31'b0, (k == 16)});
      checkOutput("busy_timing", {31'b0, busyS}, {31'b0, (k <= 16)});
      checkOutput("doneU_timing", {31'b0, doneU}, {31'b0, (k == 16)});
      if (k == 16) begin
        checkOutput("sign", {31'b0, signS}, {31'b0, eSign});
        checkOutput("bcd", {12'b0, bcdS}, {12'b0, eBcd});
        checkOutput("signU", {31'b0, signU}, 32'd0);
        checkOutput("bcdU", {12'b0, bcdU}, {12'b0, eBcdU});
      end
    end
  endtask

  initial begin
    vecs[0] = '{16'd12345, 1'b0, 20'h12345, 20'h12345};
    vecs[1] = '{16'hFFFF,  1'b1, 20'h00001, 20'h65535};
    vecs[2] = '{16'h8000,  1'b1, 20'h32768, 20'h32768};
    vecs[3] = '{16'h7FFF,  1'b0, 20'h32767, 20'h32767};
    vecs[4] = '{16'h0000,  1'b0, 20'h00000, 20'h00000};
    vecs[5] = '{16'hFF85,  1'b1, 20'h00123, 20'h65413};
    vecs[6] = '{16'h270F,  1'b0, 20'h09999, 20'h09999};
    vecs[7] = '{16'hD8F1,  1'b1, 20'h09999, 20'h55537};

    rst_n = 1'b0;
    start = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'b0, busyS}, 32'd0);
    checkOutput("reset_done", {31'b0, doneS}, 32'd0);
    checkOutput("reset_sign", {31'b0, signS}, 32'd0);
    checkOutput("reset_bcd", {12'b0, bcdS}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load a nonzero negative result, then reset asynchronously mid-conversion
    runConversion(16'hFFFF, 1'b1, 20'h00001, 20'h65535);
    applyStimulus(16'd12345);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy", {31'b0, busyS}, 32'd0);
    checkOutput("async_done", {31'b0, doneS}, 32'd0);
    checkOutput("async_sign", {31'b0, signS}, 32'd0);
    checkOutput("async_bcd", {12'b0, bcdS}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkOutput("idle_done", {31'b0, doneS}, 32'd0);
      checkOutput("idle_busy", {31'b0, busyS}, 32'd0);
      checkOutput("idle_bcd", {12'b0, bcdS}, 32'd0);
    end

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++)
      runConversion(vecs[i].vin, vecs[i].expSign, vecs[i].expBcd, vecs[i].expBcdU);

    // Back-to-back: start held high, one result every 18 cycles
    $display("[TB] back-to-back");
    @(negedge clk);
    start = 1'b1;
    value = 16'd42;
    @(posedge clk);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      checkOutput("b2b_done", {31'b0, doneS}, {31'b0, (k == 16 || k == 34)});
      if (k >= 16 && k <= 33)
        checkOutput("b2b_bcd_hold", {12'b0, bcdS}, 32'h00042);
      if (k == 16)
        value = 16'd7;
      if (k == 34) begin
        checkOutput("b2b_bcd2", {12'b0, bcdS}, 32'h00007);
        start = 1'b0;
      end
    end
    @(posedge clk);

    // start pulses while busy are ignored
    $display("[TB] start while busy");
    applyStimulus(16'd42);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3 || k == 10) begin
        start = 1'b1;
        value = 16'd999;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput("busy_ign_done", {31'b0, doneS}, {31'b0, (k == 16)});
      if (k >= 16)
        checkOutput("busy_ign_bcd", {12'b0, bcdS}, 32'h00042);
    end
    start = 1'b0;

    // Reset at E8 of a conversion aborts it without a done pulse
    $display("[TB] reset mid-operation");
    applyStimulus(16'd999);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_bcd", {12'b0, bcdS}, 32'd0);
    checkOutput("abort_sign", {31'b0, signS}, 32'd0);
    checkOutput("abort_busy", {31'b0, busyS}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_nodone", {31'b0, doneS}, 32'd0);
      checkOutput("abort_idle", {31'b0, busyS}, 32'd0);
    end
    runConversion(16'd999, 1'b0, 20'h00999, 20'h00999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin16_to_bcd_seq.md
Name: bin16_to_bcd_seq

Overview:
- Sequential double-dabble converter that sits directly downstream of the 16-bit two's-complement negation stage in the display path.
- Takes a 16-bit signed result and produces a sign flag plus five packed BCD digits of its magnitude for the seven-segment driver.
- Converts one bit per clock under a start/busy/done handshake.
- Owns its own magnitude extraction, so a negative input is negated internally using the same rule as the negation stage: invert all bits, then add 1.

Parameters:
- WIDTH, 16, binary input width. Must satisfy 10^DIGITS > 2^WIDTH.
- DIGITS, 5, number of BCD output digits. Output width is 4*DIGITS.
- SIGNED, 1. 1 = input is two's complement. 0 = input is unsigned; sign output is forced to 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a conversion; sampled only in IDLE
- value  in  WIDTH  binary operand; sampled on the same edge as start
- busy  out  1  high while a conversion is in flight (CONV and DONE states)
- done  out  1  one-cycle pulse when sign and bcd are updated
- sign  out  1  1 = value was negative
- bcd  out  4*DIGITS  packed BCD, digit 0 in [3:0], most significant digit in the top nibble

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. While rst_n=0, every register clears immediately, independent of clk: state=IDLE, busy=0, done=0, sign=0, bcd=0, shift counter=0, scratch registers=0.
- State machine has three states: IDLE, CONV, DONE.
- IDLE:
  - If start=1 at a rising edge:
    - neg = SIGNED & value[WIDTH-1].
    - mag = neg ? (~value + 1) : value, kept at WIDTH bits unsigned. 0x8000 yields mag=0x8000 = 32768, which is correct.
    - Latch neg. Load mag into the shift register. Clear the BCD scratch. Set count=0. Go to CONV.
  - If start=0, stay in IDLE.
- CONV, each edge:
  - Add 3 to every scratch BCD digit that is >= 5.
  - Then shift {scratch, mag} left one bit.
  - count++.
  - On the edge where count==WIDTH-1 (the WIDTH-th shift): copy scratch (including that final shift) to bcd, copy neg to sign, go to DONE.
- DONE: done=1 for exactly this one cycle. On the next edge go to IDLE with done=0.
- Latency: start sampled at edge E0. The CONV shifts occur on edges E1..E16 (WIDTH=16), so the FSM enters DONE on edge E16. done, together with the new bcd and sign, is visible from E16 until E17. busy is high from after E0 until E17.
- start is ignored while busy=1: no queueing and no restart. value may change freely after E0.
- sign and bcd hold their last completed result until the next DONE, or until reset. They never show partial results.
- Back-to-back operation: start held high continuously yields one conversion every WIDTH+2 cycles. The first IDLE cycle after DONE accepts the next request.
- Zero: value=0 gives sign=0, bcd=0, with normal timing.
- Negative zero cannot occur. Minimum negative input is handled as shown above.
- Reset during CONV or DONE aborts the conversion:
  - done is never pulsed.
  - Outputs return to 0.
  - After rst_n releases, the block idles until a new start.
- The add-3 correction uses 4-bit arithmetic per digit. Digits never exceed 9 after a shift.

Test Plan:
- Reset then idle: rst_n=0 asserted asynchronously mid-cycle -> busy, done, sign, bcd all 0 immediately. With rst_n=1 and start=0 for 20 cycles -> outputs stay 0 and done never pulses.
- Positive input: value=16'd12345, start pulse at E0 -> done=1 exactly from E16 to E17, sign=0, bcd=20'h12345, busy high E0..E17.
- Negative input: value=16'hFFFF (-1) -> sign=1, bcd=20'h00001. Then value=16'h8000 -> sign=1, bcd=20'h32768. Then value=16'h7FFF -> sign=0, bcd=20'h32767.
- Unsigned build (SIGNED=0): value=16'hFFFF -> sign=0, bcd=20'h65535. value=0 -> bcd=0, with done still pulsed on schedule.
- Handshake:
  - start held high continuously with value=16'd42, then 16'd7 -> conversions complete every 18 cycles.
  - start pulses while busy -> ignored. Result stays 20'h00042 from the first accepted value, with exactly one done per accepted start.
  - bcd is stable between done pulses.
- Reset mid-operation: rst_n pulsed low at E8 of a conversion of 16'd999 -> no done pulse, bcd=0 and sign=0. A fresh start after release with 16'd999 gives bcd=20'h00999.
